// File: rtl/core_net_sequencer.sv
// Network command sequencer for the 3-stage core: queues command packets and owns
// the IDLE/RUN/DRAIN/ERR run state, issuing imem writes, PC loads and fetch enable.
module core_net_sequencer #(
  parameter int IMEM_AW      = 10,
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               net_valid_i,
  input  logic [2:0]         net_cmd_i,
  input  logic [IMEM_AW-1:0] net_addr_i,
  input  logic [DATA_W-1:0]  net_data_i,
  output logic               net_ready_o,
  input  logic               wait_i,
  input  logic               exception_i,
  input  logic               stall_i,
  output logic               fetch_en_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [DATA_W-1:0]  imem_data_o,
  output logic               pc_we_o,
  output logic [IMEM_AW-1:0] pc_o,
  output logic [1:0]         state_o,
  output logic               cmd_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DC_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [2:0] CMD_IMEM_WR = 3'd1;
  localparam logic [2:0] CMD_PC_WR   = 3'd2;
  localparam logic [2:0] CMD_HALT    = 3'd3;
  localparam logic [2:0] CMD_CLR_ERR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]         cmd;
    logic [IMEM_AW-1:0] addr;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  state_e             state_q, state_d;
  logic [DC_W-1:0]    drain_q, drain_d;
  logic               fetch_en_q, fetch_en_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0]  imem_data_q, imem_data_d;
  logic               pc_we_q, pc_we_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic               cmd_err_q, cmd_err_d;

  logic   full, empty, push, pop, exc_take, head_illegal;
  entry_t head;

  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign push         = net_valid_i && !full;
  assign head         = fifo_q[rd_ptr_q];
  assign head_illegal = (head.cmd > CMD_CLR_ERR);
  assign exc_take     = exception_i && !stall_i && (state_q != ST_ERR);

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pop         = 1'b0;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    pc_we_d     = 1'b0;
    pc_d        = pc_q;
    cmd_err_d   = 1'b0;

    if (exc_take) begin
      state_d = ST_ERR;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            pop = 1'b1;
            case (head.cmd)
              CMD_IMEM_WR: begin
                imem_we_d   = 1'b1;
                imem_addr_d = head.addr;
                imem_data_d = head.data;
              end
              CMD_PC_WR: begin
                pc_we_d = 1'b1;
                pc_d    = head.addr;
                state_d = ST_RUN;
              end
              default: cmd_err_d = head_illegal;
            endcase
          end
        end
        ST_RUN: begin
          // A WAIT in execute stops the core even if a HALT is at the head.
          if (wait_i) begin
            state_d = ST_DRAIN;
            drain_d = DC_W'(DRAIN_CYCLES - 1);
          end else if (!empty) begin
            case (head.cmd)
              CMD_HALT: begin
                pop     = 1'b1;
                state_d = ST_DRAIN;
                drain_d = DC_W'(DRAIN_CYCLES - 1);
              end
              CMD_IMEM_WR, CMD_PC_WR: pop = 1'b0;
              default: begin
                pop       = 1'b1;
                cmd_err_d = head_illegal;
              end
            endcase
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_d = ST_IDLE;
          else               drain_d = drain_q - 1'b1;
        end
        ST_ERR: begin
          if (!empty) begin
            pop = 1'b1;
            if (head.cmd == CMD_CLR_ERR) state_d   = ST_IDLE;
            else                         cmd_err_d = 1'b1;
          end
        end
      endcase
    end

    fetch_en_d = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fetch_en_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      pc_we_q     <= 1'b0;
      pc_q        <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      fetch_en_q  <= fetch_en_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      pc_we_q     <= pc_we_d;
      pc_q        <= pc_d;
      cmd_err_q   <= cmd_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{cmd: net_cmd_i, addr: net_addr_i, data: net_data_i};
  end

  assign net_ready_o = !full;
  assign fetch_en_o  = fetch_en_q;
  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign pc_we_o     = pc_we_q;
  assign pc_o        = pc_q;
  assign state_o     = state_q;
  assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_core_net_sequencer.sv
// Bench for core_net_sequencer: directed boot/backpressure/stop/error scenarios followed
// by random traffic, all compared every cycle against a queue-based behavioural model.
module tb_core_net_sequencer;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  localparam int DRAIN = 3;

  localparam logic [2:0] NOP = 3'd0, IMEM_WR = 3'd1, PC_WR = 3'd2, HALT = 3'd3, CLR_ERR = 3'd4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_ERR = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          net_valid = 1'b0;
  logic [2:0]    net_cmd = '0;
  logic [AW-1:0] net_addr = '0;
  logic [DW-1:0] net_data = '0;
  logic          wait_in = 1'b0, exc_in = 1'b0, stall_in = 1'b0;
  logic          net_ready_o, fetch_en_o, imem_we_o, pc_we_o, cmd_err_o;
  logic [AW-1:0] imem_addr_o, pc_o;
  logic [DW-1:0] imem_data_o;
  logic [1:0]    state_o;

  int checks = 0;
  int failures = 0;

  core_net_sequencer #(.IMEM_AW(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset),
    .net_valid_i(net_valid), .net_cmd_i(net_cmd), .net_addr_i(net_addr), .net_data_i(net_data),
    .net_ready_o(net_ready_o),
    .wait_i(wait_in), .exception_i(exc_in), .stall_i(stall_in),
    .fetch_en_o(fetch_en_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o), .pc_we_o(pc_we_o), .pc_o(pc_o),
    .state_o(state_o), .cmd_err_o(cmd_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of packets, the run state and the DRAIN cycles still to go.
  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } pkt_t;

  pkt_t          m_q[$];
  int            m_state = S_IDLE;
  int            m_drain_left = 0;
  bit            m_valid = 1'b0;
  logic          e_imem_we = 0, e_pc_we = 0, e_cmd_err = 0;
  logic [AW-1:0] e_imem_addr = '0, e_pc = '0;
  logic [DW-1:0] e_imem_data = '0;

  always @(posedge clk) begin : model
    pkt_t h;
    bit   do_pop;
    bit   accept;
    if (reset) begin
      m_q.delete();
      m_state = S_IDLE;
      m_drain_left = 0;
      {e_imem_we, e_pc_we, e_cmd_err} = '0;
      e_imem_addr = '0;
      e_imem_data = '0;
      e_pc = '0;
      m_valid = 1'b1;
    end else begin
      accept = net_valid && (m_q.size() < DEPTH);
      do_pop = 1'b0;
      {e_imem_we, e_pc_we, e_cmd_err} = '0;
      if (m_q.size() > 0) h = m_q[0];
      if (exc_in && !stall_in && m_state != S_ERR) begin
        m_state = S_ERR;
      end else if (m_state == S_IDLE) begin
        if (m_q.size() > 0) begin
          do_pop = 1'b1;
          if (h.cmd == IMEM_WR) begin
            e_imem_we = 1; e_imem_addr = h.addr; e_imem_data = h.data;
          end else if (h.cmd == PC_WR) begin
            e_pc_we = 1; e_pc = h.addr; m_state = S_RUN;
          end else if (h.cmd > CLR_ERR) begin
            e_cmd_err = 1;
          end
        end
      end else if (m_state == S_RUN) begin
        if (wait_in) begin
          m_state = S_DRAIN; m_drain_left = DRAIN;
        end else if (m_q.size() > 0 && h.cmd != IMEM_WR && h.cmd != PC_WR) begin
          do_pop = 1'b1;
          if (h.cmd == HALT) begin
            m_state = S_DRAIN; m_drain_left = DRAIN;
          end else if (h.cmd > CLR_ERR) begin
            e_cmd_err = 1;
          end
        end
      end else if (m_state == S_DRAIN) begin
        m_drain_left--;
        if (m_drain_left == 0) m_state = S_IDLE;
      end else begin
        if (m_q.size() > 0) begin
          do_pop = 1'b1;
          if (h.cmd == CLR_ERR) m_state = S_IDLE;
          else                  e_cmd_err = 1;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (accept) m_q.push_back('{cmd: net_cmd, addr: net_addr, data: net_data});
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("net_ready", net_ready_o, (m_q.size() < DEPTH));
      check("state", state_o, m_state);
      check("fetch_en", fetch_en_o, (m_state == S_RUN));
      check("imem_we", imem_we_o, e_imem_we);
      check("imem_addr", imem_addr_o, e_imem_addr);
      check("imem_data", imem_data_o, e_imem_data);
      check("pc_we", pc_we_o, e_pc_we);
      check("pc", pc_o, e_pc);
      check("cmd_err", cmd_err_o, e_cmd_err);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Hold a packet at the source until accepted (bounded).
  task automatic send(input logic [2:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit done = 1'b0;
    net_valid = 1'b1; net_cmd = cmd; net_addr = addr; net_data = data;
    for (int i = 0; i < 50 && !done; i++) begin
      done = net_ready_o;
      tick();
    end
    net_valid = 1'b0;
    if (!done) check("send_accept", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    check("rst_state", state_o, 0);
    check("rst_ready", net_ready_o, 1);
    check("rst_fetch", fetch_en_o, 0);
    check("rst_strobes", {imem_we_o, pc_we_o, cmd_err_o}, 0);

    // Boot
    send(IMEM_WR, 10'd4, 32'hDEAD_BEEF);
    send(PC_WR, 10'd4, 32'h0);
    for (int i = 0; i < 10 && !imem_we_o; i++) tick();
    check("boot_imem_we", imem_we_o, 1);
    check("boot_imem_addr", imem_addr_o, 4);
    check("boot_imem_data", imem_data_o, 32'hDEAD_BEEF);
    for (int i = 0; i < 10 && !pc_we_o; i++) tick();
    check("boot_pc_we", pc_we_o, 1);
    check("boot_pc", pc_o, 4);
    check("boot_state", state_o, 1);
    check("boot_fetch", fetch_en_o, 1);

    // Backpressure in RUN, then WAIT stop and deferred writes
    send(IMEM_WR, 10'd8, 32'd1);
    send(IMEM_WR, 10'd9, 32'd2);
    check("bp_ready_low", net_ready_o, 0);
    net_valid = 1'b1; net_cmd = IMEM_WR; net_addr = 10'd10; net_data = 32'd3;
    tick(3);
    check("bp_still_full", net_ready_o, 0);
    check("bp_no_write_in_run", imem_we_o, 0);
    net_valid = 1'b0;
    wait_in = 1'b1;
    tick();
    wait_in = 1'b0;
    check("wait_state_drain", state_o, 2);
    check("wait_fetch_off", fetch_en_o, 0);
    tick();
    check("drain_2", state_o, 2);
    tick();
    check("drain_3", state_o, 2);
    tick();
    check("drain_done", state_o, 0);
    tick();
    check("deferred_we0", imem_we_o, 1);
    check("deferred_addr0", imem_addr_o, 8);
    tick();
    check("deferred_we1", imem_we_o, 1);
    check("deferred_addr1", imem_addr_o, 9);
    check("deferred_data1", imem_data_o, 2);
    tick();
    check("deferred_end", imem_we_o, 0);

    // Exception handling
    exc_in = 1'b1; stall_in = 1'b1;
    tick();
    check("exc_stalled", state_o, 0);
    stall_in = 1'b0;
    tick();
    exc_in = 1'b0;
    check("exc_err", state_o, 3);
    send(PC_WR, 10'd20, 32'd0);
    for (int i = 0; i < 10 && !cmd_err_o; i++) tick();
    check("err_pcwr_cmd_err", cmd_err_o, 1);
    check("err_pcwr_no_pc_we", pc_we_o, 0);
    check("err_stays", state_o, 3);
    send(CLR_ERR, 10'd0, 32'd0);
    for (int i = 0; i < 10 && state_o != 0; i++) tick();
    check("clr_err_idle", state_o, 0);
    check("clr_err_no_pulse", cmd_err_o, 0);

    // Illegal command in IDLE
    send(3'd6, 10'd1, 32'd1);
    for (int i = 0; i < 10 && !cmd_err_o; i++) tick();
    check("illegal_pulse", cmd_err_o, 1);
    check("illegal_state", state_o, 0);
    check("illegal_strobes", {imem_we_o, pc_we_o}, 0);
    tick();
    check("illegal_pulse_end", cmd_err_o, 0);

    // Reset mid-drain with a full queue
    send(PC_WR, 10'h30, 32'd0);
    for (int i = 0; i < 10 && state_o != 1; i++) tick();
    send(IMEM_WR, 10'd1, 32'd5);
    send(IMEM_WR, 10'd2, 32'd6);
    wait_in = 1'b1;
    tick();
    wait_in = 1'b0;
    check("rd_drain", state_o, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rd_state", state_o, 0);
    check("rd_ready", net_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_no_strobe", {imem_we_o, pc_we_o}, 0);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int c;
      reset     = ($urandom_range(0, 199) == 0);
      net_valid = $urandom_range(0, 1);
      c         = $urandom_range(0, 9);
      net_cmd   = (c > 7) ? PC_WR : 3'(c);
      net_addr  = AW'($urandom);
      net_data  = $urandom;
      wait_in   = ($urandom_range(0, 15) == 0);
      exc_in    = ($urandom_range(0, 24) == 0);
      stall_in  = $urandom_range(0, 1);
      tick();
    end
    {reset, net_valid, wait_in, exc_in, stall_in} = '0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
